// File: rtl/pulse_gen_param.sv
// Parametrised DAC pulse generator: decodes instruction/pulse FIFO entries and drives one
// AXIS beat per clock with tick-relative timed pulses, phase-measurement bursts and streaming.
module pulse_gen_param #(
    parameter int unsigned         SAMPLES  = 16,
    parameter int unsigned         SAMPLE_W = 16,
    parameter int unsigned         PERIOD_W = 24,
    parameter int unsigned         COARSE_W = 16,
    parameter logic [SAMPLE_W-1:0] AMP_RST  = 16'h7FFF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        instr_fifo_empty,
    input  logic [31:0]                 instr_fifo_data,
    output logic                        instr_fifo_read,
    input  logic                        pulse_fifo_empty,
    input  logic [31:0]                 pulse_fifo_data,
    output logic                        pulse_fifo_read,
    output logic [SAMPLES*SAMPLE_W-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        tick_out,
    output logic                        underrun,
    output logic                        fine_err,
    output logic [7:0]                  state_out
);
    localparam int unsigned BeatW    = SAMPLES * SAMPLE_W;
    localparam logic [7:0]  SamplesB = 8'(SAMPLES);

    localparam logic [7:0] CmdRstClk = 8'd0;
    localparam logic [7:0] CmdPulse  = 8'd1;
    localparam logic [7:0] CmdPeriod = 8'd2;
    localparam logic [7:0] CmdPmSet  = 8'd3;
    localparam logic [7:0] CmdPmClr  = 8'd4;
    localparam logic [7:0] CmdToggle = 8'd5;
    localparam logic [7:0] CmdSync   = 8'd6;
    localparam logic [7:0] CmdAmp    = 8'd7;

    typedef enum logic [7:0] {
        StIdle      = 8'd0,
        StRstRead   = 8'd1,
        StRead      = 8'd2,
        StWaitTick  = 8'd3,
        StWaitPulse = 8'd4,
        StToggle    = 8'd5,
        StSsPm      = 8'd6,
        StSsRd      = 8'd7,
        StSsLatch   = 8'd8,
        StSsTick    = 8'd9,
        StSsWait    = 8'd10
    } state_e;

    function automatic logic [BeatW-1:0] pulse_beat(input logic [7:0]          fine,
                                                    input logic [SAMPLE_W-1:0] amp);
        logic [BeatW-1:0] beat;
        beat = '0;
        for (int unsigned k = 0; k < SAMPLES; k++) begin
            if (fine == 8'(k)) beat[(SAMPLES-1-k)*SAMPLE_W +: SAMPLE_W] = amp;
        end
        return beat;
    endfunction

    state_e                state_q, state_d;
    logic [PERIOD_W-1:0]   period_q, period_d, cnt_q, cnt_d;
    logic                  tick_q, tick_d, pm_q, pm_d;
    logic [SAMPLE_W-1:0]   amp_q, amp_d;
    logic [BeatW-1:0]      out_q, out_d;
    logic                  instr_rd_q, instr_rd_d, pulse_rd_q, pulse_rd_d;
    logic [COARSE_W-1:0]   coarse_q, coarse_d, cc_q, cc_d;
    logic [7:0]            fine_q, fine_d;
    logic [23:0]           n_q, n_d;
    logic                  underrun_q, underrun_d, fine_err_q, fine_err_d;

    logic [7:0]            cmd;
    logic                  pm_tick, emit, drain, bad;
    logic [23:0]           n_cmd;
    logic [PERIOD_W-1:0]   per_new;
    logic                  unused_pulse_hi;

    assign cmd             = instr_fifo_data[31:24];
    // A PM default beat is on the output in this cycle.
    assign pm_tick         = pm_q & tick_q;
    assign unused_pulse_hi = ^pulse_fifo_data[31:24];

    always_comb begin
        state_d    = state_q;
        period_d   = period_q;
        cnt_d      = (cnt_q >= period_q - PERIOD_W'(1)) ? '0 : cnt_q + PERIOD_W'(1);
        tick_d     = (cnt_q == '0);
        amp_d      = amp_q;
        pm_d       = pm_q;
        out_d      = '0;
        instr_rd_d = 1'b0;
        pulse_rd_d = 1'b0;
        coarse_d   = coarse_q;
        fine_d     = fine_q;
        cc_d       = cc_q;
        n_d        = n_q;
        underrun_d = underrun_q | ~m_axis_tready;
        fine_err_d = fine_err_q;
        emit       = 1'b0;
        drain      = 1'b0;
        bad        = 1'b0;
        n_cmd      = (cmd == CmdToggle) ? 24'(instr_fifo_data[15:0]) : instr_fifo_data[23:0];
        per_new    = PERIOD_W'(instr_fifo_data[23:0]);

        case (state_q)
            StIdle: begin
                if (!instr_fifo_empty) begin
                    instr_rd_d = 1'b1;
                    state_d    = StRstRead;
                end
            end
            StRstRead: state_d = StRead;
            StRead: begin
                state_d = StIdle;
                case (cmd)
                    CmdRstClk: begin
                        cnt_d = '0;
                        out_d = pulse_beat(8'd0, amp_q);
                    end
                    CmdPulse: begin
                        coarse_d = COARSE_W'(instr_fifo_data[23:8]);
                        fine_d   = instr_fifo_data[7:0];
                        state_d  = StWaitTick;
                    end
                    CmdPeriod: period_d = (per_new < PERIOD_W'(2)) ? PERIOD_W'(2) : per_new;
                    CmdPmSet:  pm_d = 1'b1;
                    CmdPmClr:  pm_d = 1'b0;
                    CmdToggle, CmdSync: begin
                        if (n_cmd == '0 || (pm_tick && n_cmd == 24'd1)) begin
                            pm_d  = 1'b0;
                            drain = (cmd == CmdSync);
                        end else begin
                            pm_d    = 1'b1;
                            n_d     = pm_tick ? n_cmd - 24'd1 : n_cmd;
                            state_d = (cmd == CmdToggle) ? StToggle : StSsPm;
                        end
                    end
                    CmdAmp:  amp_d = instr_fifo_data[SAMPLE_W-1:0];
                    default: ;
                endcase
            end
            StWaitTick, StSsTick: begin
                if (tick_q) begin
                    if (coarse_q == '0) begin
                        emit = 1'b1;
                    end else begin
                        cc_d    = coarse_q - COARSE_W'(1);
                        state_d = (state_q == StWaitTick) ? StWaitPulse : StSsWait;
                    end
                end
            end
            StWaitPulse, StSsWait: begin
                if (cc_q == '0) emit = 1'b1;
                else            cc_d = cc_q - COARSE_W'(1);
            end
            StToggle, StSsPm: begin
                if (pm_tick) begin
                    if (n_q == 24'd1) begin
                        pm_d    = 1'b0;
                        state_d = StIdle;
                        drain   = (state_q == StSsPm);
                    end else begin
                        n_d = n_q - 24'd1;
                    end
                end
            end
            StSsRd: state_d = StSsLatch;
            StSsLatch: begin
                coarse_d = COARSE_W'(pulse_fifo_data[23:8]);
                fine_d   = pulse_fifo_data[7:0];
                state_d  = StSsTick;
            end
            default: bad = 1'b1;
        endcase

        // An out-of-range fine offset is dropped but the schedule advances as if emitted.
        if (emit) begin
            if (fine_q < SamplesB) out_d = pulse_beat(fine_q, amp_q);
            else                   fine_err_d = 1'b1;
            state_d = StIdle;
            drain   = (state_q == StSsTick) || (state_q == StSsWait);
        end

        if (drain) begin
            if (!pulse_fifo_empty) begin
                pulse_rd_d = 1'b1;
                state_d    = StSsRd;
            end else begin
                state_d = StIdle;
            end
        end

        if (bad) begin
            state_d    = StIdle;
            period_d   = PERIOD_W'(10);
            cnt_d      = '0;
            tick_d     = 1'b0;
            amp_d      = AMP_RST;
            pm_d       = 1'b0;
            out_d      = '0;
            instr_rd_d = 1'b0;
            pulse_rd_d = 1'b0;
            coarse_d   = '0;
            fine_d     = '0;
            cc_d       = '0;
            n_d        = '0;
            underrun_d = 1'b0;
            fine_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            period_q   <= PERIOD_W'(10);
            cnt_q      <= '0;
            tick_q     <= 1'b0;
            amp_q      <= AMP_RST;
            pm_q       <= 1'b0;
            out_q      <= '0;
            instr_rd_q <= 1'b0;
            pulse_rd_q <= 1'b0;
            coarse_q   <= '0;
            fine_q     <= '0;
            cc_q       <= '0;
            n_q        <= '0;
            underrun_q <= 1'b0;
            fine_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            period_q   <= period_d;
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
            amp_q      <= amp_d;
            pm_q       <= pm_d;
            out_q      <= out_d;
            instr_rd_q <= instr_rd_d;
            pulse_rd_q <= pulse_rd_d;
            coarse_q   <= coarse_d;
            fine_q     <= fine_d;
            cc_q       <= cc_d;
            n_q        <= n_d;
            underrun_q <= underrun_d;
            fine_err_q <= fine_err_d;
        end
    end

    // PM mode bypasses the output register: default beat on tick beats, silence otherwise.
    assign m_axis_tdata    = pm_q ? (tick_q ? pulse_beat(8'd0, amp_q) : '0) : out_q;
    assign m_axis_tvalid   = 1'b1;
    assign tick_out        = tick_q;
    assign underrun        = underrun_q;
    assign fine_err        = fine_err_q;
    assign state_out       = state_q;
    assign instr_fifo_read = instr_rd_q;
    assign pulse_fifo_read = pulse_rd_q;

endmodule

// File: doc/pulse_gen_param.md
# pulse_gen_param

Parametrised successor pulse generator for the RFSoC DAC path. Decodes commands from the instruction FIFO and timed pulse entries from the pulse FIFO, and drives one AXIS beat of SAMPLES samples per clock, with a pulse placed at a coarse (beat) and fine (sample) offset from the periodic clock tick. Compared with the first-generation block it adds configurable beat geometry, a programmable pulse amplitude, fine-offset range checking, back-pressure detection and exact pulse counts in phase-measurement bursts.

## Interface
Parameters:
- SAMPLES, 16: samples per AXIS beat, power of 2, range 2..32
- SAMPLE_W, 16: bits per sample
- PERIOD_W, 24: tick-period counter width
- COARSE_W, 16: coarse-delay width
- AMP_RST, 16'h7FFF: amplitude after reset

Ports:
- clk  in  1  RFSoC fabric clock, the only clock
- rst  in  1  asynchronous, active-low reset
- instr_fifo_empty  in  1  instruction FIFO empty
- instr_fifo_data  in  32  [31:24] cmd, [23:8] coarse, [7:0] fine/arg
- instr_fifo_read  out  1  one-cycle read strobe
- pulse_fifo_empty  in  1  pulse FIFO empty
- pulse_fifo_data  in  32  [23:8] coarse, [7:0] fine
- pulse_fifo_read  out  1  one-cycle read strobe
- m_axis_tdata  out  SAMPLES*SAMPLE_W  beat; sample k at bits [(SAMPLES-1-k)*SAMPLE_W +: SAMPLE_W]
- m_axis_tvalid  out  1  tied to 1 after reset
- m_axis_tready  in  1  sink ready
- tick_out  out  1  high in every beat where the period counter is 0
- underrun  out  1  sticky: tready was low in some cycle
- fine_err  out  1  sticky: a pulse was dropped because fine >= SAMPLES
- state_out  out  8  current FSM state code

## Operation
- Period counter: PERIOD_W bits, counts 0..period-1 and wraps; tick when the counter is 0. A stored period below 2 is forced to 2. Reset period is 10.
- Pulse beat: all zero except sample `fine`, which is set to `amp`. The default beat is a pulse at fine = 0.
- FSM states (state_out code): IDLE 0, RST_READ 1, READ 2, WAIT_TICK 3, WAIT_PULSE 4, TOGGLE 5, SS_PM 6, SS_RD 7, SS_LATCH 8, SS_TICK 9, SS_WAIT 10. Any other code resets all registers.
- IDLE: clears the output register. If the instruction FIFO is not empty, asserts instr_fifo_read and moves to RST_READ, then READ, where the data is sampled.
- Commands:
  - 0, reset clock: counter goes to 0 on the next edge; the output register carries the default beat.
  - 1, send pulse: latch coarse and fine, then go to WAIT_TICK.
  - 2, set period: period = data[23:0] truncated to PERIOD_W.
  - 3 / 4: set / clear phase-measurement (PM) mode.
  - 5, toggle: PM on for exactly N = data[15:0] tick beats, then off. N = 0 emits nothing.
  - 6, sync-and-stream: PM for N = data[23:0] ticks, then drain the pulse FIFO.
  - 7, set amplitude: amp = data[SAMPLE_W-1:0].
  - Other codes: ignored; return to IDLE.
- PM mode: the default beat is output on tick beats and zero on all other beats. The output register is bypassed.
- Timed pulse, from WAIT_TICK or SS_TICK at the first tick t0: the output register carries the pulse beat in cycle t0+C+1, for exactly one beat.
- Streaming: after the PM phase, each pulse-FIFO entry goes read strobe → latch → wait for tick → coarse count → emit. The next entry's read strobe is issued in the emit cycle. When the FIFO is empty at the emit cycle, the FSM returns to IDLE.
- Fine >= SAMPLES: the entry is dropped with no output, fine_err is set, and the FSM proceeds as if the pulse had been emitted.
- Coarse arithmetic saturates at 0. Counters never wrap negative.
- underrun sets in any cycle with m_axis_tready = 0. Output and timing do not stall. It is cleared only by rst.

## Timing
- rst low: all outputs 0 except m_axis_tvalid. tdata = 0, strobes = 0, state = IDLE, amp = AMP_RST, PM = 0.
- Instruction latency: empty seen low → read strobe on the next edge → command executes 2 cycles after the strobe.
- A command-0 beat and a counter reset land in the same output cycle. tick_out goes high one cycle later.
- A toggle or sync command arriving when the counter is already 0 counts that tick only if PM is already on. Otherwise counting starts at the next tick.
- Reset asserted mid-stream aborts immediately. FIFO entries not yet strobed are left untouched.

## Test plan
- Reset, then period = 8 and send pulse C = 0, F = 3 → a single beat one cycle after a tick, with sample 3 = 16'h7FFF and all other samples 0.
- Set amplitude 16'h1234, send C = 2, F = 15 → pulse in cycle t0+3 with sample 15 = 16'h1234; tick_out spacing is 8 cycles.
- Toggle N = 4, period = 5 → exactly 4 default beats spaced 5 cycles apart, then PM off; N = 0 → no beats.
- Sync-and-stream N = 2 with pulse FIFO {C=0,F=1}, {C=1,F=20} at SAMPLES = 16 → 2 PM beats, one pulse at sample 1, then fine_err = 1 with no second pulse, then IDLE.
- Period 0 and period 1 → tick every 2 cycles. Reset-clock command → default beat, then tick_out high the next cycle.
- Drive tready = 0 for one cycle during a stream → underrun = 1 and sticky; pulse timing unchanged; rst low clears it.
